// File: rtl/sd_pkg.sv
// sd_pkg: shared defaults, lock-state type and frame-length helper for the
// standard-definition sync controller.
package sd_pkg;

    localparam int DEF_VS_LEN      = 90;
    localparam int DEF_LINE_LEN    = 414;
    localparam int DEF_LOCK_FRAMES = 2;
    localparam int DEF_MIN_LINES   = 300;
    localparam int DEF_MAX_LINES   = 320;

    // Ceiling of the 10-bit line and write-column counters.
    localparam logic [9:0] CNT10_MAX = 10'd1023;
    // Ceiling of the 8-bit csync low-run counter.
    localparam logic [7:0] SYNC_LEN_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    // True when a frame's line count lies inside the inclusive window [lo, hi].
    function automatic logic in_range(input logic [9:0] v,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sd_sync_ctrl_csync_sep.sv
// csync_sep: samples composite sync once per ce tick, measures the low run and
// flags rising edges and vsync detection. The strobes are combinational from the
// current csync sample so the parent can register its outputs in the same tick.
module csync_sep
    import sd_pkg::*;
#(
    parameter int VS_LEN = DEF_VS_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ce_2pix,
    input  logic csync,
    output logic edge_det,
    output logic vs_det,
    output logic short_sync
);

    localparam logic [7:0] VS_LEN_W = 8'(VS_LEN);

    logic       cs_d_r;
    logic [7:0] sync_len_r;

    // Delayed csync sample and saturating low-run length
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_d_r     <= 1'b1;
            sync_len_r <= 8'd0;
        end else if (ce_2pix) begin
            cs_d_r <= csync;
            if (csync) begin
                sync_len_r <= 8'd0;
            end else if (sync_len_r != SYNC_LEN_MAX) begin
                sync_len_r <= sync_len_r + 8'd1;
            end else begin
                sync_len_r <= sync_len_r;
            end
        end else begin
            cs_d_r     <= cs_d_r;
            sync_len_r <= sync_len_r;
        end
    end

    // Rising edge: previous sample low, current sample high.
    assign edge_det   = ce_2pix & ~cs_d_r & csync;
    // Vsync fires once, when the low run reaches VS_LEN with csync still low.
    assign vs_det     = ce_2pix & ~csync & (sync_len_r == VS_LEN_W);
    // A pulse shorter than VS_LEN is an ordinary hsync.
    assign short_sync = (sync_len_r < VS_LEN_W);

endmodule

// File: rtl/sd_sync_ctrl.sv
// sd_sync_ctrl: line-buffer bank/column control and frame lock tracking driven
// by composite sync. All outputs are registered and advance only on ce_2pix.
// Optional build macro SD_FREERUN_EN: when the read counter wraps without any
// csync edge since the previous wrap, a line event is synthesised so the
// buffers keep turning over while sync is absent.
module sd_sync_ctrl
    import sd_pkg::*;
#(
    parameter int VS_LEN      = DEF_VS_LEN,
    parameter int LINE_LEN    = DEF_LINE_LEN,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
    parameter int MIN_LINES   = DEF_MIN_LINES,
    parameter int MAX_LINES   = DEF_MAX_LINES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_2pix,
    input  logic       csync,
    output logic       wr_bank,
    output logic       rd_bank,
    output logic [8:0] wr_col,
    output logic       wr_en,
    output logic [8:0] rd_col,
    output logic       line_start,
    output logic       vs_pulse,
    output logic       vs_active,
    output logic [9:0] line_cnt,
    output logic       scanline,
    output logic       locked
);

    localparam logic [8:0] RD_LAST = 9'(LINE_LEN - 1);
    localparam logic [9:0] MIN_W   = 10'(MIN_LINES);
    localparam logic [9:0] MAX_W   = 10'(MAX_LINES);
    localparam logic [7:0] LOCK_W  = 8'(LOCK_FRAMES);

    logic        edge_s;
    logic        vs_s;
    logic        short_s;
    logic        hs_s;
    logic        wrap_s;
    logic        synth_s;
    logic        line_ev_s;
    logic        frame_ok_s;
    logic [9:0]  zx_col_r;
    logic [9:0]  zx_next_s;
    logic [7:0]  good_r;
    lock_state_t state_r;

    csync_sep #(
        .VS_LEN (VS_LEN)
    ) u_csync_sep (
        .clk        (clk),
        .reset      (reset),
        .ce_2pix    (ce_2pix),
        .csync      (csync),
        .edge_det   (edge_s),
        .vs_det     (vs_s),
        .short_sync (short_s)
    );

    assign hs_s       = edge_s & short_s;
    assign wrap_s     = ce_2pix & (rd_col == RD_LAST);
    assign frame_ok_s = in_range(line_cnt, MIN_W, MAX_W);

`ifdef SD_FREERUN_EN
    logic seen_edge_r;

    // Remember whether any csync edge arrived since the last read wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_edge_r <= 1'b0;
        end else if (wrap_s) begin
            seen_edge_r <= 1'b0;
        end else if (edge_s) begin
            seen_edge_r <= 1'b1;
        end else begin
            seen_edge_r <= seen_edge_r;
        end
    end

    assign synth_s = wrap_s & ~seen_edge_r & ~edge_s;
`else
    assign synth_s = 1'b0;
`endif

    assign line_ev_s = edge_s | synth_s;

    // Next write column: restart on a new line, otherwise count and park at the top
    always_comb begin
        zx_next_s = zx_col_r;
        if (hs_s || synth_s) begin
            zx_next_s = 10'd0;
        end else if (ce_2pix && (zx_col_r != CNT10_MAX)) begin
            zx_next_s = zx_col_r + 10'd1;
        end else begin
            zx_next_s = zx_col_r;
        end
    end

    // Line-level counters, bank selects and pulse outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zx_col_r   <= 10'd0;
            wr_col     <= 9'd0;
            wr_en      <= 1'b0;
            rd_col     <= 9'd0;
            wr_bank    <= 1'b1;
            rd_bank    <= 1'b0;
            line_cnt   <= 10'd0;
            line_start <= 1'b0;
            vs_pulse   <= 1'b0;
            vs_active  <= 1'b0;
            scanline   <= 1'b0;
        end else if (ce_2pix) begin
            zx_col_r   <= zx_next_s;
            wr_col     <= zx_next_s[9:1];
            wr_en      <= zx_next_s[0] & (zx_next_s != CNT10_MAX);
            line_start <= hs_s;
            vs_pulse   <= vs_s;
            if (line_ev_s) begin
                wr_bank <= ~wr_bank;
                rd_bank <= ~rd_bank;
            end
            // A vsync clear beats a concurrent line increment.
            if (vs_s) begin
                line_cnt <= 10'd0;
            end else if (line_ev_s && (line_cnt != CNT10_MAX)) begin
                line_cnt <= line_cnt + 10'd1;
            end
            if (vs_s) begin
                vs_active <= 1'b1;
            end else if (edge_s) begin
                vs_active <= 1'b0;
            end
            // An hsync landing on the wrap column is a single restart, one toggle.
            if (hs_s || wrap_s) begin
                rd_col <= 9'd0;
            end else begin
                rd_col <= rd_col + 9'd1;
            end
            if (vs_s) begin
                scanline <= 1'b0;
            end else if (hs_s || wrap_s) begin
                scanline <= ~scanline;
            end
        end
    end

    // Lock tracker: qualifies the finished frame's line count at each vsync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_SEARCH;
            good_r  <= 8'd0;
            locked  <= 1'b0;
        end else if (ce_2pix) begin
            locked <= (state_r == ST_LOCKED);
            case (state_r)
                ST_SEARCH: begin
                    if (vs_s) begin
                        state_r <= ST_TRAIN;
                        good_r  <= 8'd0;
                    end
                end
                ST_TRAIN: begin
                    if (vs_s) begin
                        if (frame_ok_s) begin
                            good_r <= good_r + 8'd1;
                            if ((good_r + 8'd1) >= LOCK_W) begin
                                state_r <= ST_LOCKED;
                            end
                        end else begin
                            good_r <= 8'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if ((vs_s && !frame_ok_s) || (line_cnt == CNT10_MAX)) begin
                        state_r <= ST_SEARCH;
                        good_r  <= 8'd0;
                    end
                end
                default: begin
                    state_r <= ST_SEARCH;
                    good_r  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sync_ctrl.sv
// tb_sd_sync_ctrl: directed scenarios plus randomized csync/ce stimulus, checked
// every cycle against an event-level reference model of the sync controller.
module tb_sd_sync_ctrl;

    localparam int VS_LEN      = 90;
    localparam int LINE_LEN    = 414;
    localparam int LOCK_FRAMES = 2;
    localparam int MIN_LINES   = 300;
    localparam int MAX_LINES   = 320;
`ifdef SD_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       ce_2pix;
    logic       csync;
    logic       wr_bank;
    logic       rd_bank;
    logic [8:0] wr_col;
    logic       wr_en;
    logic [8:0] rd_col;
    logic       line_start;
    logic       vs_pulse;
    logic       vs_active;
    logic [9:0] line_cnt;
    logic       scanline;
    logic       locked;

    sd_sync_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ce_2pix    (ce_2pix),
        .csync      (csync),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .wr_col     (wr_col),
        .wr_en      (wr_en),
        .rd_col     (rd_col),
        .line_start (line_start),
        .vs_pulse   (vs_pulse),
        .vs_active  (vs_active),
        .line_cnt   (line_cnt),
        .scanline   (scanline),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    localparam int S_SEARCH = 0, S_TRAIN = 1, S_LOCKED = 2;
    int m_prev, m_low, m_zx, m_rd, m_wb, m_lc, m_vsp, m_vsa, m_ls, m_sl;
    int m_st, m_good, m_lk, m_seen;
    bit chk_en = 1'b0;

    function automatic int sat(input int v, input int top);
        return (v > top) ? top : v;
    endfunction

    function automatic bit good_len(input int n);
        return (n >= MIN_LINES) && (n <= MAX_LINES);
    endfunction

    task automatic m_reset();
        m_prev = 1; m_low = 0; m_zx = 0; m_rd = 0; m_wb = 1; m_lc = 0;
        m_vsp = 0; m_vsa = 0; m_ls = 0; m_sl = 0;
        m_st = S_SEARCH; m_good = 0; m_lk = 0; m_seen = 0;
    endtask

    task automatic m_step(input int cs);
        bit e_edge, e_vs, e_hs, e_wrap, e_syn, e_line;
        e_edge = (m_prev == 0) && (cs == 1);
        e_vs   = (cs == 0) && (m_low == VS_LEN);
        e_hs   = e_edge && (m_low < VS_LEN);
        e_wrap = (m_rd == LINE_LEN - 1);
        e_syn  = FREERUN && e_wrap && (m_seen == 0) && !e_edge;
        e_line = e_edge || e_syn;
        // lock status reports the state held before this tick
        m_lk = (m_st == S_LOCKED) ? 1 : 0;
        if (m_st == S_SEARCH) begin
            if (e_vs) begin m_st = S_TRAIN; m_good = 0; end
        end else if (m_st == S_TRAIN) begin
            if (e_vs) begin
                if (good_len(m_lc)) begin
                    m_good++;
                    if (m_good >= LOCK_FRAMES) m_st = S_LOCKED;
                end else m_good = 0;
            end
        end else begin
            if ((e_vs && !good_len(m_lc)) || m_lc == 1023) begin m_st = S_SEARCH; m_good = 0; end
        end
        if (e_vs) m_lc = 0;
        else if (e_line) m_lc = sat(m_lc + 1, 1023);
        if (e_line) m_wb = 1 - m_wb;
        m_zx = (e_hs || e_syn) ? 0 : sat(m_zx + 1, 1023);
        m_rd = (e_hs || e_wrap) ? 0 : m_rd + 1;
        if (e_vs) m_sl = 0;
        else if (e_hs || e_wrap) m_sl = 1 - m_sl;
        if (e_vs) m_vsa = 1;
        else if (e_edge) m_vsa = 0;
        m_vsp = e_vs ? 1 : 0;
        m_ls  = e_hs ? 1 : 0;
        if (e_wrap) m_seen = 0;
        else if (e_edge) m_seen = 1;
        m_low  = (cs == 1) ? 0 : sat(m_low + 1, 255);
        m_prev = cs;
    endtask

    // Cycle-by-cycle comparison of every output against the reference model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_bank",    int'(wr_bank),    m_wb);
            chk("rd_bank",    int'(rd_bank),    1 - m_wb);
            chk("wr_col",     int'(wr_col),     m_zx / 2);
            chk("wr_en",      int'(wr_en),      int'((m_zx % 2 == 1) && (m_zx != 1023)));
            chk("rd_col",     int'(rd_col),     m_rd);
            chk("line_start", int'(line_start), m_ls);
            chk("vs_pulse",   int'(vs_pulse),   m_vsp);
            chk("vs_active",  int'(vs_active),  m_vsa);
            chk("line_cnt",   int'(line_cnt),   m_lc);
            chk("scanline",   int'(scanline),   m_sl);
            chk("locked",     int'(locked),     m_lk);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic cs, input logic ce);
        csync   = cs;
        ce_2pix = ce;
        @(posedge clk);
        if (reset) m_reset();
        else if (ce) m_step(int'(cs));
        @(negedge clk);
    endtask

    task automatic rst_lits(input string tag);
        chk({tag, "_wr_bank"},    int'(wr_bank),    1);
        chk({tag, "_rd_bank"},    int'(rd_bank),    0);
        chk({tag, "_wr_col"},     int'(wr_col),     0);
        chk({tag, "_wr_en"},      int'(wr_en),      0);
        chk({tag, "_rd_col"},     int'(rd_col),     0);
        chk({tag, "_line_start"}, int'(line_start), 0);
        chk({tag, "_vs_pulse"},   int'(vs_pulse),   0);
        chk({tag, "_vs_active"},  int'(vs_active),  0);
        chk({tag, "_line_cnt"},   int'(line_cnt),   0);
        chk({tag, "_scanline"},   int'(scanline),   0);
        chk({tag, "_locked"},     int'(locked),     0);
    endtask

    int r_lc_pre, r_vs_at, r_lk0, r_lk1, r_lc_at, r_va_pre, r_va_post, r_ls_e;

    // 100-tick vsync pulse followed by 8 high ticks; records what happened
    task automatic vsync_pulse();
        r_lc_pre = int'(line_cnt);
        r_vs_at = -1; r_lk0 = -1; r_lk1 = -1; r_lc_at = -1;
        for (int i = 1; i <= 100; i++) begin
            tick(1'b0, 1'b1);
            if (r_vs_at < 0 && vs_pulse === 1'b1) begin
                r_vs_at = i; r_lk0 = int'(locked); r_lc_at = int'(line_cnt);
            end else if (r_vs_at > 0 && i == r_vs_at + 1) begin
                r_lk1 = int'(locked);
            end
        end
        r_va_pre = int'(vs_active);
        tick(1'b1, 1'b1);
        r_ls_e = int'(line_start);
        r_va_post = int'(vs_active);
        repeat (7) tick(1'b1, 1'b1);
    endtask

    task automatic sline();
        repeat (4) tick(1'b0, 1'b1);
        repeat (4) tick(1'b1, 1'b1);
    endtask

    // Frame of n lines: the vsync line plus n-1 short hsync lines
    task automatic frame(input int n);
        vsync_pulse();
        repeat (n - 1) sline();
    endtask

    int t, last_ls, max_wc, vs_cnt, ls_extra, rd_pre, sl_pre, wb_pre;
    int toggles, wb_last, lc0, cyc, lo, hi;

    initial begin
        reset = 1'b1; csync = 1'b1; ce_2pix = 1'b0;
        m_reset();
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_lits("reset");
        reset = 1'b0;

        // model pins: hand-computed values for its start state
        chk("model_wb_reset", m_wb, 1);
        chk("model_state_reset", m_st, S_SEARCH);

        // csync held high: buffers only turn over in the free-running build
        repeat (414) tick(1'b1, 1'b1);
        toggles = 0; ls_extra = 0; wb_last = int'(wr_bank); lc0 = int'(line_cnt);
        repeat (1242) begin
            tick(1'b1, 1'b1);
            if (int'(wr_bank) != wb_last) toggles++;
            wb_last = int'(wr_bank);
            if (line_start) ls_extra++;
        end
        chk("freerun_bank_toggles", toggles, FREERUN ? 3 : 0);
        chk("freerun_line_cnt_delta", int'(line_cnt) - lc0, FREERUN ? 3 : 0);
        chk("freerun_no_line_start", ls_extra, 0);

        // hsync 30 low every 414 ticks
        t = 0; last_ls = 0; max_wc = 0; vs_cnt = 0; ls_extra = 0;
        for (int ln = 0; ln < 5; ln++) begin
            repeat (30) begin
                tick(1'b0, 1'b1); t++;
                if (vs_pulse) vs_cnt++;
                if (ln >= 1 && int'(wr_col) > max_wc) max_wc = int'(wr_col);
            end
            rd_pre = int'(rd_col); sl_pre = int'(scanline); wb_pre = int'(wr_bank);
            tick(1'b1, 1'b1); t++;
            chk("line_start_on_edge", int'(line_start), 1);
            chk("bank_swap_per_line", int'(wr_bank), 1 - wb_pre);
            if (ln >= 1) begin
                chk("rd_col_before_edge", rd_pre, 413);
                chk("rd_col_after_edge", int'(rd_col), 0);
                chk("scanline_single_toggle", int'(scanline), 1 - sl_pre);
                chk("line_period", t - last_ls, 414);
            end
            last_ls = t;
            repeat (383) begin
                tick(1'b1, 1'b1); t++;
                if (vs_pulse) vs_cnt++;
                if (line_start) ls_extra++;
                if (ln >= 1 && int'(wr_col) > max_wc) max_wc = int'(wr_col);
            end
        end
        chk("wr_col_peak", max_wc, 206);
        chk("hsync_no_vsync", vs_cnt, 0);
        chk("hsync_no_extra_line_start", ls_extra, 0);

        // long sync then lock acquisition
        frame(310);
        chk("vs_pulse_tick", r_vs_at, 91);
        chk("vs_line_cnt_cleared", r_lc_at, 0);
        chk("vs_active_before_edge", r_va_pre, 1);
        chk("vs_active_after_edge", r_va_post, 0);
        chk("no_line_start_after_vsync", r_ls_e, 0);
        frame(310);
        chk("frame_len_seen", r_lc_pre, 310);
        chk("lock_not_after_first_good", r_lk1, 0);
        frame(310);
        chk("lock_low_at_vsync", r_lk0, 0);
        chk("lock_one_tick_later", r_lk1, 1);

        // asynchronous reset mid-frame
        repeat (150) sline();
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        chk("locked_before_reset", int'(locked), 1);
        chk("model_locked_pin", m_lk, 1);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        rst_lits("async_reset");
        @(negedge clk);
        repeat (3) tick(1'b0, 1'b1);
        reset = 1'b0;
        tick(1'b1, 1'b1);
        chk("release_no_line_start", int'(line_start), 0);
        chk("release_wr_bank", int'(wr_bank), 1);
        chk("release_line_cnt", int'(line_cnt), 0);

        // relock needs LOCK_FRAMES+1 vsyncs
        frame(310);
        frame(310);
        chk("relock_not_at_second", r_lk1, 0);
        frame(310);
        chk("relock_at_third", r_lk1, 1);
        frame(250);
        chk("stay_locked_on_good", r_lk1, 1);
        vsync_pulse();
        chk("short_frame_len", r_lc_pre, 250);
        chk("unlock_at_vsync_tick", r_lk0, 1);
        chk("unlock_one_tick_later", r_lk1, 0);

        // randomized csync runs with sparse clock enable
        cyc = 0;
        while (cyc < 15000) begin
            lo = ($urandom_range(0, 6) == 0) ? int'($urandom_range(85, 130))
                                             : int'($urandom_range(1, 40));
            hi = int'($urandom_range(1, 450));
            repeat (lo) begin tick(1'b0, ($urandom_range(0, 3) != 0)); cyc++; end
            repeat (hi) begin tick(1'b1, ($urandom_range(0, 3) != 0)); cyc++; end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
